// File: rtl/twos_to_sign_magnitude.sv
// Bit-serial two's-complement to sign-magnitude converter.
// Walks the operand LSB first. Bits are copied until the first 1 is seen,
// and every later bit is inverted, but only for negative operands.
//
//   state | meaning
//   IDLE  | waiting for Start, last results held on the outputs
//   SHIFT | converting one bit per edge, N edges in total
//   DONE  | one-cycle Done pulse, then back to IDLE
module twos_to_sign_magnitude #(
  parameter int N = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] In,
  output logic         Busy,
  output logic         Done,
  output logic         Sign,
  output logic [N-1:0] Mag,
  output logic         MinNeg
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  sreg;
  logic [N-1:0]  res;
  logic [CW-1:0] cnt;
  logic          seen;
  logic          sgn;

  logic          out_bit;
  logic          last_bit;
  logic [N-1:0]  res_next;

  // Current output bit and the result register as it will look after this shift.
  always_comb begin
    out_bit  = (sgn & seen) ? ~sreg[0] : sreg[0];
    res_next = {out_bit, res[N-1:1]};
    last_bit = (cnt == CW'(N-1));
  end

  // Sequencing, serial datapath and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      sreg   <= '0;
      res    <= '0;
      cnt    <= '0;
      seen   <= 1'b0;
      sgn    <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Sign   <= 1'b0;
      Mag    <= '0;
      MinNeg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            sreg  <= In;
            sgn   <= In[N-1];
            seen  <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            Busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg >> 1;
          res  <= res_next;
          seen <= seen | sreg[0];
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            // Before this edge, seen covers bits 0..N-2 only. If none of
            // them was 1, a negative operand is the most negative value.
            Mag    <= res_next;
            Sign   <= sgn;
            MinNeg <= sgn & ~seen;
            Done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_to_sign_magnitude.sv
// Directed bench for twos_to_sign_magnitude. It uses an N=8 instance for the
// timing and handshake scenarios and an N=4 instance for a full input sweep.
module tb_twos_to_sign_magnitude;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] in8 = '0;
  logic       busy8, done8, sign8, minneg8;
  logic [7:0] mag8;

  logic       start4 = 1'b0;
  logic [3:0] in4 = '0;
  logic       busy4, done4, sign4, minneg4;
  logic [3:0] mag4;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  twos_to_sign_magnitude #(.N(8)) u8 (
    .Clk(Clk), .Reset(Reset), .Start(start8), .In(in8),
    .Busy(busy8), .Done(done8), .Sign(sign8), .Mag(mag8), .MinNeg(minneg8)
  );

  twos_to_sign_magnitude #(.N(4)) u4 (
    .Clk(Clk), .Reset(Reset), .Start(start4), .In(in4),
    .Busy(busy4), .Done(done4), .Sign(sign4), .Mag(mag4), .MinNeg(minneg4)
  );

  // This task only drives one conversion and records what it observes. The
  // scenario tasks do all of the checking. The task is called just after an
  // edge, with the N=8 instance idle.
  task automatic run_conv(input logic [7:0] val, output int done_cnt,
                          output int done_edge, output int busy_cnt,
                          output bit hold_ok);
    logic [8:0] held;
    held      = {sign8, mag8};
    hold_ok   = 1'b1;
    done_cnt  = 0;
    done_edge = -1;
    in8       = val;
    start8    = 1'b1;
    @(posedge Clk); #1;
    start8    = 1'b0;
    in8       = ~val;
    busy_cnt  = int'(busy8);
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk); #1;
      busy_cnt += int'(busy8);
      if (done8) begin
        done_cnt++;
        done_edge = i;
      end
      if (i < 8 && {sign8, mag8} !== held) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({busy8, done8, sign8, minneg8, mag8} !== 12'h000) begin
      $display("FAIL reset_n8: got busy=%b done=%b sign=%b minneg=%b mag=%h, want all 0",
               busy8, done8, sign8, minneg8, mag8);
    end else passed++;
    total++;
    if ({busy4, done4, sign4, minneg4, mag4} !== 8'h00) begin
      $display("FAIL reset_n4: got busy=%b done=%b sign=%b minneg=%b mag=%h, want all 0",
               busy4, done4, sign4, minneg4, mag4);
    end else passed++;
    #19;
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic_neg;
    int dc, de, bc;
    bit ho;
    run_conv(8'hFB, dc, de, bc, ho);
    total++;
    if ({sign8, mag8, minneg8} !== {1'b1, 8'h05, 1'b0}) begin
      $display("FAIL fb_result: got sign=%b mag=%h minneg=%b, want 1 05 0", sign8, mag8, minneg8);
    end else passed++;
    total++;
    if (dc !== 1 || de !== 8) begin
      $display("FAIL fb_done: got count=%0d edge=%0d, want 1 at edge 8", dc, de);
    end else passed++;
    total++;
    if (bc !== 9) begin
      $display("FAIL fb_busy: got %0d busy cycles, want 9", bc);
    end else passed++;
  endtask

  task automatic test_positive_seq;
    logic [7:0] vals [3] = '{8'h05, 8'h00, 8'h7F};
    int dc, de, bc;
    bit ho;
    for (int j = 0; j < 3; j++) begin
      run_conv(vals[j], dc, de, bc, ho);
      total++;
      if ({sign8, mag8, minneg8} !== {1'b0, vals[j], 1'b0}) begin
        $display("FAIL pos_result[%0d]: got sign=%b mag=%h minneg=%b, want 0 %h 0",
                 j, sign8, mag8, minneg8, vals[j]);
      end else passed++;
      total++;
      if (dc !== 1) begin
        $display("FAIL pos_done[%0d]: got %0d done pulses, want 1", j, dc);
      end else passed++;
      total++;
      if (!ho) begin
        $display("FAIL pos_hold[%0d]: got outputs changing mid-conversion, want held", j);
      end else passed++;
    end
  endtask

  task automatic test_min_neg;
    int dc, de, bc;
    bit ho;
    run_conv(8'h80, dc, de, bc, ho);
    total++;
    if ({sign8, mag8, minneg8} !== {1'b1, 8'h80, 1'b1}) begin
      $display("FAIL minneg_80: got sign=%b mag=%h minneg=%b, want 1 80 1", sign8, mag8, minneg8);
    end else passed++;
    run_conv(8'hFF, dc, de, bc, ho);
    total++;
    if ({sign8, mag8, minneg8} !== {1'b1, 8'h01, 1'b0}) begin
      $display("FAIL neg_ff: got sign=%b mag=%h minneg=%b, want 1 01 0", sign8, mag8, minneg8);
    end else passed++;
    total++;
    if (!ho) begin
      $display("FAIL ff_hold: got outputs changing mid-conversion, want held");
    end else passed++;
  endtask

  // Start is held high while In changes every edge. Only the values on edges
  // 0, 10 and 20 may be taken: F0 -> (1,10), 33 -> (0,33), 81 -> (1,7F).
  task automatic test_back_to_back;
    logic [7:0] vals [30];
    logic [8:0] want_sm [3] = '{{1'b1, 8'h10}, {1'b0, 8'h33}, {1'b1, 8'h7F}};
    int done_seen = 0;
    for (int c = 0; c < 30; c++) vals[c] = 8'hAA ^ 8'(c);
    vals[0]  = 8'hF0;
    vals[10] = 8'h33;
    vals[20] = 8'h81;
    start8 = 1'b1;
    in8    = vals[0];
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk); #1;
      if (c < 29) in8 = vals[c+1];
      total++;
      if (done8 !== ((c % 10) == 8)) begin
        $display("FAIL b2b_done@%0d: got %b, want %b", c, done8, (c % 10) == 8);
      end else passed++;
      total++;
      if (busy8 !== ((c % 10) != 9)) begin
        $display("FAIL b2b_busy@%0d: got %b, want %b", c, busy8, (c % 10) != 9);
      end else passed++;
      if ((c % 10) == 8) begin
        total++;
        if ({sign8, mag8} !== want_sm[done_seen] || minneg8 !== 1'b0) begin
          $display("FAIL b2b_result[%0d]: got sign=%b mag=%h minneg=%b, want %b %h 0",
                   done_seen, sign8, mag8, minneg8, want_sm[done_seen][8], want_sm[done_seen][7:0]);
        end else passed++;
        done_seen++;
      end
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset_mid;
    int dc, de, bc, dpost, bpost;
    bit ho;
    in8    = 8'hC4;
    start8 = 1'b1;
    @(posedge Clk); #1;
    start8 = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    #2;
    Reset = 1'b1;
    #1;
    total++;
    if ({busy8, done8, sign8, minneg8, mag8} !== 12'h000) begin
      $display("FAIL reset_mid: got busy=%b done=%b sign=%b minneg=%b mag=%h, want all 0",
               busy8, done8, sign8, minneg8, mag8);
    end else passed++;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    dpost = 0;
    bpost = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      dpost += int'(done8);
      bpost += int'(busy8);
    end
    total++;
    if (dpost !== 0 || bpost !== 0) begin
      $display("FAIL reset_discard: got done=%0d busy=%0d cycles after release, want 0 0", dpost, bpost);
    end else passed++;
    run_conv(8'hC4, dc, de, bc, ho);
    total++;
    if ({sign8, mag8, minneg8} !== {1'b1, 8'h3C, 1'b0} || dc !== 1) begin
      $display("FAIL c4_after_reset: got sign=%b mag=%h minneg=%b dones=%0d, want 1 3c 0 1",
               sign8, mag8, minneg8, dc);
    end else passed++;
  endtask

  task automatic test_sweep4;
    logic [3:0] want_mag [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                  4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    int dc, de;
    for (int v = 0; v < 16; v++) begin
      in4    = 4'(v);
      start4 = 1'b1;
      @(posedge Clk); #1;
      start4 = 1'b0;
      dc = 0;
      de = -1;
      for (int i = 1; i <= 6; i++) begin
        @(posedge Clk); #1;
        if (done4) begin
          dc++;
          de = i;
        end
      end
      total++;
      if (mag4 !== want_mag[v] || sign4 !== (v >= 8) || minneg4 !== (v == 8)) begin
        $display("FAIL sweep4[%0d]: got sign=%b mag=%h minneg=%b, want %b %h %b",
                 v, sign4, mag4, minneg4, v >= 8, want_mag[v], v == 8);
      end else passed++;
      total++;
      if (dc !== 1 || de !== 4) begin
        $display("FAIL sweep4_done[%0d]: got count=%0d edge=%0d, want 1 at edge 4", v, dc, de);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_neg();
    test_positive_seq();
    test_min_neg();
    test_back_to_back();
    test_reset_mid();
    test_sweep4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
